mem_stage_pipe: RTL and testbench
=================================

# mem_stage_pipe

Parametrised memory stage that succeeds the fixed 16-bit EX/MEM-plus-data-memory stage. It registers an execute-stage op, performs a single-port word memory access that occupies `ACC_CYC` cycles, and presents the result to writeback under a valid/stall handshake. It adds flush, out-of-range address detection, and optional byte-lane writes. It sits between the execute stage and the writeback stage.

## Interface
- `DATA_W`, 16: data and ALU-result width; must be a multiple of 8.
- `ADDR_W`, 8: word-address width; memory depth is 2^ADDR_W words.
- `RD_W`, 3: destination-register index width.
- `ACC_CYC`, 1: cycles one memory access occupies; must be ≥1.

Ports (name, direction, width, meaning):
- `clk` input 1: clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `in_valid` input 1: execute stage presents an op.
- `ready` output 1: stage accepts an op this cycle.
- `in_reg_write`, `in_reg_store`, `in_mem_write`, `in_mem_read` input 1 each: control bits.
- `in_alu_result` input DATA_W: address for memory ops; pass-through value for all ops.
- `in_third_arg` input DATA_W: store data.
- `in_byte_en` input DATA_W/8: store lane mask; used only with the macro described under Configuration.
- `in_rd` input RD_W: destination register.
- `flush` input 1: synchronous kill of the held op.
- `wb_stall` input 1: writeback cannot take the output.
- `out_valid` output 1: outputs hold a completed op.
- `out_reg_write`, `out_reg_store` output 1 each: control bits for the completed op.
- `out_alu_result` output DATA_W: ALU result of the completed op.
- `out_load_data` output DATA_W: load data of the completed op.
- `out_rd` output RD_W: destination register of the completed op.
- `addr_err` output 1: sticky flag for an out-of-range access.

## Operation
- The FSM has three states: EMPTY, ACCESS and FULL.
- **EMPTY:** `ready`=1, `out_valid`=0.
  - Accepted memory op (`in_mem_read` or `in_mem_write`) → ACCESS, with counter loaded to ACC_CYC−1.
  - Accepted non-memory op → FULL.
- **ACCESS:** `ready`=0. The counter decrements each cycle.
  - At the edge where the counter is 0, the write commits or the read data is captured into `out_load_data`, and the state → FULL.
  - With ACC_CYC=1, the commit happens at the first edge after accept.
- **FULL:** `out_valid`=1 and `ready`=!`wb_stall`.
  - If `wb_stall`=0, the output is consumed at the edge. An op accepted at the same edge is handled exactly as from EMPTY; with no op accepted, the state → EMPTY.
  - If `wb_stall`=1, all outputs hold.
- **Write plus read:** `in_mem_write` and `in_mem_read` both high is treated as a store.
- **Store result:** a store's `out_load_data` is 0.
- **Non-memory result:** a non-memory op's `out_load_data` is 0.
- **Address:** the word index is `in_alu_result[ADDR_W-1:0]`.
  - A memory op with any higher bit set is out of range. At commit, such an op sets `addr_err`, suppresses the write, and returns `out_load_data`=0. It still completes normally.
- **`addr_err` clearing:** cleared only by reset.
- **Flush:** `flush` has the highest priority.
  - Any state → EMPTY at the edge, with `out_valid`=0 the next cycle.
  - An op in ACCESS is aborted: no write, no `addr_err` update.
  - `in_valid` is ignored in a flush cycle.
- **Reset:** `reset` low forces state EMPTY, counter 0, every output register and `addr_err` to 0, and aborts any pending write. Memory contents are not reset.

## Timing
- Non-memory op accepted at edge E: `out_valid` is high from E to the first unstalled edge.
- Memory op accepted at edge E: commit and `out_valid` rise at edge E+ACC_CYC.
- Store data is visible to a load accepted at any later edge. With a single op in flight, no read-during-write case exists.
- Sustained throughput:
  - Non-memory ops: 1 op per cycle.
  - Memory ops: 1 op per ACC_CYC+1 cycles, because `ready`=0 throughout ACCESS.
- `ready` is combinational from state and `wb_stall` only. It does not depend on `in_valid`.

## Configuration
- Macro: `MEMSTAGE_BYTE_WRITE_EN`.
- **Macro defined:** a store writes only the bytes whose `in_byte_en` bit is set (bit i ↔ bits 8i+7:8i). A mask of all zeros writes nothing, but the store still completes. Loads always return the full word.
- **Macro not defined:** `in_byte_en` is ignored and stores write the full word.
- The port exists in both builds.

## Test plan
- **Store then load, ACC_CYC=2:** store 0xBEEF to address 0x05, then load 0x05 → `out_load_data`=0xBEEF. Each op's `out_valid` comes 2 edges after its accept, and `ready`=0 during ACCESS.
- **Non-memory op:** rd=3, alu=0x1234 → next cycle `out_valid`=1, `out_rd`=3, `out_alu_result`=0x1234, `out_load_data`=0. Back-to-back non-memory ops complete 1 per cycle.
- **Stall:** `wb_stall`=1 for 3 cycles in FULL → outputs stable and `ready`=0. On release with `in_valid`=1, the new op is accepted at the same edge the old one is consumed.
- **Flush and reset:** mem[0x07]=0x2222.
  - Flush during ACCESS of a store of 0x1111 to 0x07 → a later load returns 0x2222.
  - Repeat with `reset` low mid-ACCESS → all outputs 0 immediately, and no write occurs.
- **Out-of-range store:** `ADDR_W`=8, alu=0x0105 → `addr_err`=1, still set after 10 further cycles, and mem[0x05] is unchanged.
- **Byte write:** mem[0x02]=0xAAAA, store 0x1234 with `in_byte_en`=2'b01.
  - Macro defined → load returns 0xAA34.
  - Macro not defined → load returns 0x1234.

Source files
------------

// File: rtl/mem_stage_pipe.sv
// Memory stage: registers one execute op, runs an ACC_CYC-cycle word access, hands result to writeback.
// Optional macro MEMSTAGE_BYTE_WRITE_EN enables byte-lane stores via in_byte_en.
module mem_stage_pipe #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 8,
   parameter int RD_W    = 3,
   parameter int ACC_CYC = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                ready,
   input  logic                in_reg_write,
   input  logic                in_reg_store,
   input  logic                in_mem_write,
   input  logic                in_mem_read,
   input  logic [DATA_W-1:0]   in_alu_result,
   input  logic [DATA_W-1:0]   in_third_arg,
   input  logic [DATA_W/8-1:0] in_byte_en,
   input  logic [RD_W-1:0]     in_rd,
   input  logic                flush,
   input  logic                wb_stall,
   output logic                out_valid,
   output logic                out_reg_write,
   output logic                out_reg_store,
   output logic [DATA_W-1:0]   out_alu_result,
   output logic [DATA_W-1:0]   out_load_data,
   output logic [RD_W-1:0]     out_rd,
   output logic                addr_err
);

   localparam int LANES = DATA_W / 8;
   localparam int CNT_W = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {S_EMPTY, S_ACCESS, S_FULL} state_e;

   state_e              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                op_write_q;
   logic                op_oor_q;
   logic [ADDR_W-1:0]   op_addr_q;
   logic [DATA_W-1:0]   op_wdata_q;

   logic                out_valid_q;
   logic                out_reg_write_q;
   logic                out_reg_store_q;
   logic [DATA_W-1:0]   out_alu_result_q;
   logic [DATA_W-1:0]   out_load_data_q;
   logic [RD_W-1:0]     out_rd_q;
   logic                addr_err_q;

   logic [DATA_W-1:0]   mem [DEPTH];
   logic [DATA_W-1:0]   rdata;
   logic [DATA_W-1:0]   wr_word;
   logic                commit;
   logic                mem_we;

   assign ready  = (state_q == S_EMPTY) || ((state_q == S_FULL) && !wb_stall);
   assign rdata  = mem[op_addr_q];
   assign commit = (state_q == S_ACCESS) && (cnt_q == '0) && !flush;
   assign mem_we = commit && op_write_q && !op_oor_q;

`ifdef MEMSTAGE_BYTE_WRITE_EN
   logic [LANES-1:0] op_be_q;

   // Unselected lanes keep the old word contents.
   always_comb begin
      wr_word = rdata;
      for (int i = 0; i < LANES; i++) begin
         if (op_be_q[i]) wr_word[8*i +: 8] = op_wdata_q[8*i +: 8];
      end
   end
`else
   logic unused_byte_en;
   assign unused_byte_en = ^in_byte_en;

   always_comb begin
      wr_word = op_wdata_q;
   end
`endif

   // NOTE: the storage array has no reset; only the control state around it does.
   always_ff @(posedge clk) begin
      if (mem_we) mem[op_addr_q] <= wr_word;
   end

   // NOTE: every sequential assignment is non-blocking so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q          <= S_EMPTY;
         cnt_q            <= '0;
         op_write_q       <= 1'b0;
         op_oor_q         <= 1'b0;
         op_addr_q        <= '0;
         op_wdata_q       <= '0;
`ifdef MEMSTAGE_BYTE_WRITE_EN
         op_be_q          <= '0;
`endif
         out_valid_q      <= 1'b0;
         out_reg_write_q  <= 1'b0;
         out_reg_store_q  <= 1'b0;
         out_alu_result_q <= '0;
         out_load_data_q  <= '0;
         out_rd_q         <= '0;
         addr_err_q       <= 1'b0;
      end else if (flush) begin
         state_q     <= S_EMPTY;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
      end else if (state_q == S_ACCESS) begin
         if (cnt_q == '0) begin
            state_q         <= S_FULL;
            out_valid_q     <= 1'b1;
            out_load_data_q <= (op_write_q || op_oor_q) ? '0 : rdata;
            if (op_oor_q) addr_err_q <= 1'b1;
         end else begin
            cnt_q <= cnt_q - CNT_W'(1);
         end
      end else if (in_valid && ready) begin
         // Accept from EMPTY, or from FULL in the same edge the old result is consumed.
         out_reg_write_q  <= in_reg_write;
         out_reg_store_q  <= in_reg_store;
         out_alu_result_q <= in_alu_result;
         out_rd_q         <= in_rd;
         out_load_data_q  <= '0;
         if (in_mem_read || in_mem_write) begin
            state_q     <= S_ACCESS;
            out_valid_q <= 1'b0;
            cnt_q       <= CNT_W'(ACC_CYC - 1);
            op_write_q  <= in_mem_write;
            op_oor_q    <= (in_alu_result >> ADDR_W) != '0;
            op_addr_q   <= in_alu_result[ADDR_W-1:0];
            op_wdata_q  <= in_third_arg;
`ifdef MEMSTAGE_BYTE_WRITE_EN
            op_be_q     <= in_byte_en;
`endif
         end else begin
            state_q     <= S_FULL;
            out_valid_q <= 1'b1;
         end
      end else if ((state_q == S_FULL) && !wb_stall) begin
         state_q     <= S_EMPTY;
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid      = out_valid_q;
   assign out_reg_write  = out_reg_write_q;
   assign out_reg_store  = out_reg_store_q;
   assign out_alu_result = out_alu_result_q;
   assign out_load_data  = out_load_data_q;
   assign out_rd         = out_rd_q;
   assign addr_err       = addr_err_q;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Bench for mem_stage_pipe (ACC_CYC=2): transaction-level model checked every cycle plus
// directed literal expectations. Honours MEMSTAGE_BYTE_WRITE_EN for the byte-lane case.
`timescale 1ns/1ps
module tb_mem_stage_pipe;

   localparam int DW  = 16;
   localparam int AW  = 8;
   localparam int RW  = 3;
   localparam int ACC = 2;

`ifdef MEMSTAGE_BYTE_WRITE_EN
   localparam logic [15:0] EXP_BYTE = 16'hAA34;
`else
   localparam logic [15:0] EXP_BYTE = 16'h1234;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          in_valid = 1'b0;
   logic          ready;
   logic          in_reg_write = 1'b0, in_reg_store = 1'b0;
   logic          in_mem_write = 1'b0, in_mem_read = 1'b0;
   logic [DW-1:0] in_alu_result = '0, in_third_arg = '0;
   logic [1:0]    in_byte_en = 2'b11;
   logic [RW-1:0] in_rd = '0;
   logic          flush = 1'b0, wb_stall = 1'b0;
   logic          out_valid, out_reg_write, out_reg_store, addr_err;
   logic [DW-1:0] out_alu_result, out_load_data;
   logic [RW-1:0] out_rd;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_stage_pipe #(.DATA_W(DW), .ADDR_W(AW), .RD_W(RW), .ACC_CYC(ACC)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .ready(ready),
      .in_reg_write(in_reg_write), .in_reg_store(in_reg_store),
      .in_mem_write(in_mem_write), .in_mem_read(in_mem_read),
      .in_alu_result(in_alu_result), .in_third_arg(in_third_arg),
      .in_byte_en(in_byte_en), .in_rd(in_rd), .flush(flush), .wb_stall(wb_stall),
      .out_valid(out_valid), .out_reg_write(out_reg_write), .out_reg_store(out_reg_store),
      .out_alu_result(out_alu_result), .out_load_data(out_load_data),
      .out_rd(out_rd), .addr_err(addr_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   typedef struct {
      logic        rw, rs, is_mem, is_wr, fin;
      logic [15:0] alu, wdata, ld;
      logic [1:0]  be;
      logic [2:0]  rd;
      int          done;
   } item_t;

   item_t       mq[$];
   logic [15:0] mmem [256];
   logic        m_err = 1'b0;
   int          cyc = 0;

   function automatic logic model_valid();
      return (mq.size() > 0) && (mq[0].done <= cyc);
   endfunction

   function automatic logic model_ready();
      return (mq.size() == 0) || (model_valid() && !wb_stall);
   endfunction

   task automatic m_finalize();
      item_t       it;
      logic [15:0] mask;
      it = mq[0];
      it.ld = 16'h0;
`ifdef MEMSTAGE_BYTE_WRITE_EN
      mask = {{8{it.be[1]}}, {8{it.be[0]}}};
`else
      mask = 16'hFFFF;
`endif
      if (it.is_mem && it.alu[15:8] != 8'h00) m_err = 1'b1;
      else if (it.is_wr) mmem[it.alu[7:0]] = (mmem[it.alu[7:0]] & ~mask) | (it.wdata & mask);
      else if (it.is_mem) it.ld = mmem[it.alu[7:0]];
      it.fin = 1'b1;
      mq[0] = it;
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mq.delete();
         m_err = 1'b0;
      end else begin
         logic  vld, rdy;
         item_t it;
         vld = model_valid();
         rdy = model_ready();
         cyc++;
         if (flush) begin
            mq.delete();
         end else begin
            if (vld && !wb_stall) void'(mq.pop_front());
            if (in_valid && rdy) begin
               it.rw = in_reg_write;  it.rs = in_reg_store;
               it.is_mem = in_mem_write | in_mem_read;
               it.is_wr = in_mem_write;
               it.alu = in_alu_result; it.wdata = in_third_arg;
               it.be = in_byte_en;     it.rd = in_rd;
               it.ld = 16'h0;          it.fin = 1'b0;
               it.done = cyc + (it.is_mem ? ACC : 0);
               mq.push_back(it);
            end
            if (mq.size() > 0 && !mq[0].fin && mq[0].done == cyc) m_finalize();
         end
      end
   end

   // Single compare process: every cycle out of reset.
   always @(negedge clk) begin
      if (reset) begin
         logic ev;
         ev = model_valid();
         check("ready", ready, model_ready());
         check("out_valid", out_valid, ev);
         check("addr_err", addr_err, m_err);
         if (ev) begin
            check("out_rd", out_rd, mq[0].rd);
            check("out_alu_result", out_alu_result, mq[0].alu);
            check("out_load_data", out_load_data, mq[0].ld);
            check("out_reg_write", out_reg_write, mq[0].rw);
            check("out_reg_store", out_reg_store, mq[0].rs);
         end
      end
   end

   // ---------------- driver ----------------
   task automatic send(input logic mw, input logic mr, input logic rw, input logic rs,
                       input logic [15:0] alu, input logic [15:0] data,
                       input logic [1:0] be, input logic [2:0] rd);
      logic acc;
      acc = 1'b0;
      in_mem_write = mw; in_mem_read = mr; in_reg_write = rw; in_reg_store = rs;
      in_alu_result = alu; in_third_arg = data; in_byte_en = be; in_rd = rd;
      in_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk); #1;
         acc = model_ready() && !flush;
         @(posedge clk); #2;
         if (acc) break;
      end
      in_valid = 1'b0;
      check("send_accepted", acc, 1);
   endtask

   task automatic wait_valid();
      logic ok;
      ok = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      check("wait_valid_timeout", ok, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #2;
      check("rst_out_valid", out_valid, 0);
      check("rst_addr_err", addr_err, 0);
      check("rst_out_load_data", out_load_data, 0);
      check("rst_ready", ready, 1);
      reset = 1'b1;
      @(posedge clk); #2;

      // Store 0xBEEF -> 0x05, then load it back; two-edge access latency
      send(1, 0, 0, 1, 16'h0005, 16'hBEEF, 2'b11, 3'd0);
      @(negedge clk);
      check("acc_ready_low", ready, 0);
      check("acc_lat_edge1", out_valid, 0);
      @(negedge clk);
      check("acc_lat_edge2", out_valid, 0);
      @(negedge clk);
      check("acc_lat_edge3", out_valid, 1);
      check("store_load_zero", out_load_data, 16'h0000);
      send(0, 1, 1, 0, 16'h0005, 16'h0000, 2'b11, 3'd2);
      wait_valid();
      check("load_beef", out_load_data, 16'hBEEF);

      // Non-memory op, then four back-to-back
      @(posedge clk); #2;
      send(0, 0, 1, 0, 16'h1234, 16'h0000, 2'b11, 3'd3);
      @(negedge clk);
      check("nm_valid", out_valid, 1);
      check("nm_rd", out_rd, 3);
      check("nm_alu", out_alu_result, 16'h1234);
      check("nm_load_zero", out_load_data, 0);
      @(posedge clk); #2;
      for (int i = 1; i <= 4; i++)
         send(0, 0, i[0], i[1], 16'h1000 + 16'(i), 16'h0000, 2'b11, 3'(i));
      @(negedge clk);
      check("b2b_last_rd", out_rd, 4);
      check("b2b_last_alu", out_alu_result, 16'h1004);

      // Writeback stall holds outputs; release accepts a new op on the same edge
      @(posedge clk); #2;
      send(0, 0, 1, 1, 16'h5555, 16'h0000, 2'b11, 3'd5);
      wb_stall = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("stall_ready", ready, 0);
         check("stall_alu", out_alu_result, 16'h5555);
         check("stall_rd", out_rd, 5);
      end
      @(posedge clk); #2;
      wb_stall = 1'b0;
      send(0, 0, 0, 0, 16'h6666, 16'h0000, 2'b11, 3'd6);
      @(negedge clk);
      check("release_valid", out_valid, 1);
      check("release_alu", out_alu_result, 16'h6666);

      // Flush aborts an in-flight store
      @(posedge clk); #2;
      send(1, 0, 0, 1, 16'h0007, 16'h2222, 2'b11, 3'd0);
      wait_valid();
      @(posedge clk); #2;
      send(1, 0, 0, 1, 16'h0007, 16'h1111, 2'b11, 3'd0);
      flush = 1'b1;
      @(posedge clk); #2;
      flush = 1'b0;
      @(negedge clk);
      check("flush_valid_low", out_valid, 0);
      send(0, 1, 1, 0, 16'h0007, 16'h0000, 2'b11, 3'd1);
      wait_valid();
      check("flush_no_write", out_load_data, 16'h2222);

      // Reset mid-access: outputs clear immediately, no write
      @(posedge clk); #2;
      send(1, 0, 0, 1, 16'h0007, 16'h1111, 2'b11, 3'd4);
      #1 reset = 1'b0;
      #1;
      check("rstmid_valid", out_valid, 0);
      check("rstmid_rd", out_rd, 0);
      check("rstmid_alu", out_alu_result, 0);
      check("rstmid_load", out_load_data, 0);
      check("rstmid_wflags", {out_reg_write, out_reg_store, addr_err}, 0);
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      send(0, 1, 1, 0, 16'h0007, 16'h0000, 2'b11, 3'd1);
      wait_valid();
      check("rst_no_write", out_load_data, 16'h2222);

      // Out-of-range store: sticky flag, write suppressed
      @(posedge clk); #2;
      send(1, 0, 0, 1, 16'h0105, 16'h9999, 2'b11, 3'd0);
      wait_valid();
      check("oor_err_set", addr_err, 1);
      repeat (10) @(negedge clk);
      check("oor_err_sticky", addr_err, 1);
      send(0, 1, 1, 0, 16'h0005, 16'h0000, 2'b11, 3'd2);
      wait_valid();
      check("oor_mem_unchanged", out_load_data, 16'hBEEF);
      send(0, 1, 1, 0, 16'h0205, 16'h0000, 2'b11, 3'd2);
      wait_valid();
      check("oor_load_zero", out_load_data, 16'h0000);

      // Write plus read is a store
      send(1, 1, 0, 1, 16'h0010, 16'h4321, 2'b11, 3'd0);
      wait_valid();
      check("wr_rd_load_zero", out_load_data, 0);
      send(0, 1, 1, 0, 16'h0010, 16'h0000, 2'b11, 3'd7);
      wait_valid();
      check("wr_rd_is_store", out_load_data, 16'h4321);

      // Byte-lane store
      send(1, 0, 0, 1, 16'h0002, 16'hAAAA, 2'b11, 3'd0);
      wait_valid();
      send(1, 0, 0, 1, 16'h0002, 16'h1234, 2'b01, 3'd0);
      wait_valid();
      send(0, 1, 1, 0, 16'h0002, 16'h0000, 2'b11, 3'd3);
      wait_valid();
      check("byte_write", out_load_data, EXP_BYTE);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
